// File: rtl/csr_mtrap_unit.sv
// Machine-mode CSR file and trap unit: CSRRW/S/C, counters, interrupt arbitration, trap/mret sequencing.
// Read data, illegal_csr, irq_req and trap_vec are combinational; state commits on the edge; stall blocks CSR writes and retire counting.
module csr_mtrap_unit #(
  parameter int unsigned NUM_LIRQ = 4,
  parameter bit          VECTORED = 1'b1,
  parameter int unsigned CNT_W    = 64,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                stall,
  input  logic                                csr_cmd,
  input  logic [11:0]                         csr_adr,
  input  logic [2:0]                          csr_op,
  input  logic [4:0]                          csr_uimm,
  input  logic [31:0]                         rs1_data,
  output logic [31:0]                         csr_rd_data,
  output logic                                illegal_csr,
  input  logic                                retire,
  input  logic                                trap_exc,
  input  logic [3:0]                          exc_code,
  input  logic [31:0]                         exc_tval,
  input  logic                                irq_ack,
  input  logic [29:0]                         pc_trap,
  input  logic                                cmd_mret,
  input  logic                                ext_irq,
  input  logic                                tmr_irq,
  input  logic                                sw_irq,
  input  logic [(NUM_LIRQ>0?NUM_LIRQ:1)-1:0]  lirq,
  output logic                                irq_req,
  output logic [29:0]                         trap_vec,
  output logic [29:0]                         mepc_out
);
  localparam logic [31:0] LIRQ_MASK = ((32'h1 << NUM_LIRQ) - 32'h1) << 16;
  localparam logic [31:0] IRQ_MASK  = LIRQ_MASK | 32'h0000_0888;

  logic             st_mie, st_mpie;
  logic [1:0]       st_mpp;
  logic [31:0]      mie_q, mip_q, mtvec_q, mscratch_q, mcause_q, mtval_q;
  logic [29:0]      mepc_q;
  logic             inh_cy, inh_ir;
  logic [CNT_W-1:0] mcycle_q, minstret_q;

  logic [63:0] cyc64, ins64, cyc_nxt, ins_nxt;
  logic [31:0] rdata, src, wdata, mip_nxt, pend;
  logic        valid, wr;
  logic [4:0]  irq_code;
  logic        take_exc, take_irq, take_mret;

  assign cyc64 = 64'(mcycle_q);
  assign ins64 = 64'(minstret_q);

  always_comb begin
    rdata = '0;
    valid = 1'b1;
    case (csr_adr)
      12'h300: rdata = {19'b0, st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      12'h301: rdata = MISA_VAL;
      12'h304: rdata = mie_q;
      12'h305: rdata = mtvec_q;
      12'h320: rdata = {29'b0, inh_ir, 1'b0, inh_cy};
      12'h340: rdata = mscratch_q;
      12'h341: rdata = {mepc_q, 2'b00};
      12'h342: rdata = mcause_q;
      12'h343: rdata = mtval_q;
      12'h344: rdata = mip_q;
      12'hB00, 12'hC00: rdata = cyc64[31:0];
      12'hB80, 12'hC80: rdata = cyc64[63:32];
      12'hB02, 12'hC02: rdata = ins64[31:0];
      12'hB82, 12'hC82: rdata = ins64[63:32];
      default: valid = 1'b0;
    endcase
  end

  // Every CSR op counts as a write (even RS/RC with a zero source), so the C-page aliases are always illegal.
  assign csr_rd_data = rdata;
  assign illegal_csr = csr_cmd & (~valid | (csr_adr[11:8] == 4'hC));
  assign wr          = csr_cmd & ~stall & ~illegal_csr & (csr_op[1:0] != 2'b00);

  always_comb begin
    src = csr_op[2] ? {27'b0, csr_uimm} : rs1_data;
    case (csr_op[1:0])
      2'b10:   wdata = rdata | src;
      2'b11:   wdata = rdata & ~src;
      default: wdata = src;
    endcase
  end

  always_comb begin
    mip_nxt     = '0;
    mip_nxt[11] = ext_irq;
    mip_nxt[7]  = tmr_irq;
    mip_nxt[3]  = sw_irq;
    for (int i = 0; i < NUM_LIRQ; i++) mip_nxt[16+i] = lirq[i];
  end

  // Lowest-priority candidates are assigned first so later assignments win.
  assign pend = mip_q & mie_q;
  always_comb begin
    irq_code = '0;
    for (int i = NUM_LIRQ - 1; i >= 0; i--) if (pend[16+i]) irq_code = 5'(16 + i);
    if (pend[7])  irq_code = 5'd7;
    if (pend[3])  irq_code = 5'd3;
    if (pend[11]) irq_code = 5'd11;
  end

  assign irq_req   = st_mie & (|pend);
  assign take_exc  = trap_exc;
  assign take_irq  = ~trap_exc & irq_ack & irq_req;
  assign take_mret = ~trap_exc & ~take_irq & cmd_mret;

  assign trap_vec = (VECTORED && (mtvec_q[1:0] == 2'b01) && take_irq) ?
                    mtvec_q[31:2] + {25'b0, irq_code} : mtvec_q[31:2];
  assign mepc_out = mepc_q;

  always_comb begin
    cyc_nxt = cyc64;
    ins_nxt = ins64;
    if (wr && csr_adr == 12'hB00)      cyc_nxt[31:0]  = wdata;
    else if (wr && csr_adr == 12'hB80) cyc_nxt[63:32] = wdata;
    else if (!inh_cy)                  cyc_nxt = cyc64 + 64'd1;
    if (wr && csr_adr == 12'hB02)      ins_nxt[31:0]  = wdata;
    else if (wr && csr_adr == 12'hB82) ins_nxt[63:32] = wdata;
    else if (retire && !stall && !inh_ir) ins_nxt = ins64 + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      st_mpp     <= 2'b00;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mepc_q     <= '0;
      inh_cy     <= 1'b0;
      inh_ir     <= 1'b0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mip_q      <= mip_nxt;
      mcycle_q   <= cyc_nxt[CNT_W-1:0];
      minstret_q <= ins_nxt[CNT_W-1:0];

      // A trap or mret owns mstatus/mepc/mcause/mtval this cycle; a colliding CSR write is dropped.
      if (take_exc || take_irq) begin
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
        st_mpp   <= 2'b11;
        mepc_q   <= pc_trap;
        mcause_q <= take_exc ? {28'b0, exc_code} : {1'b1, 26'b0, irq_code};
        mtval_q  <= take_exc ? exc_tval : 32'h0;
      end else if (take_mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
        st_mpp  <= 2'b11;
      end else if (wr) begin
        case (csr_adr)
          12'h300: begin
            st_mie  <= wdata[3];
            st_mpie <= wdata[7];
            st_mpp  <= wdata[12:11];
          end
          12'h341: mepc_q   <= wdata[31:2];
          12'h342: mcause_q <= wdata;
          12'h343: mtval_q  <= wdata;
          default: ;
        endcase
      end

      if (wr) begin
        case (csr_adr)
          12'h304: mie_q      <= wdata & IRQ_MASK;
          12'h305: mtvec_q    <= {wdata[31:2], 1'b0, VECTORED && (wdata[1:0] == 2'b01)};
          12'h320: begin
            inh_cy <= wdata[0];
            inh_ir <= wdata[2];
          end
          12'h340: mscratch_q <= wdata;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_csr_mtrap_unit.sv
// Directed bench for csr_mtrap_unit: CSR ops, traps, interrupt arbitration, counters, illegal access.
module tb_csr_mtrap_unit;
  logic        clk = 1'b0;
  logic        rst_n, stall, csr_cmd, retire, trap_exc, irq_ack, cmd_mret;
  logic        ext_irq, tmr_irq, sw_irq, illegal_csr, irq_req;
  logic [11:0] csr_adr;
  logic [2:0]  csr_op;
  logic [4:0]  csr_uimm;
  logic [31:0] rs1_data, csr_rd_data, exc_tval;
  logic [3:0]  exc_code, lirq;
  logic [29:0] pc_trap, trap_vec, mepc_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] d;
  logic        il;

  csr_mtrap_unit #(.NUM_LIRQ(4), .VECTORED(1'b1), .CNT_W(64), .MISA_VAL(32'h4000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .csr_cmd(csr_cmd), .csr_adr(csr_adr),
    .csr_op(csr_op), .csr_uimm(csr_uimm), .rs1_data(rs1_data), .csr_rd_data(csr_rd_data),
    .illegal_csr(illegal_csr), .retire(retire), .trap_exc(trap_exc), .exc_code(exc_code),
    .exc_tval(exc_tval), .irq_ack(irq_ack), .pc_trap(pc_trap), .cmd_mret(cmd_mret),
    .ext_irq(ext_irq), .tmr_irq(tmr_irq), .sw_irq(sw_irq), .lirq(lirq),
    .irq_req(irq_req), .trap_vec(trap_vec), .mepc_out(mepc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-time look at a CSR: stall holds off the commit, so the counters are not disturbed.
  task automatic peek(input logic [11:0] adr, output logic [31:0] val, output logic ill);
    csr_cmd = 1'b1; csr_op = 3'b010; rs1_data = 32'h0; csr_adr = adr; stall = 1'b1;
    #1;
    val = csr_rd_data; ill = illegal_csr;
    csr_cmd = 1'b0; stall = 1'b0;
  endtask

  task automatic wr(input logic [2:0] op, input logic [11:0] adr, input logic [31:0] val,
                    input logic stl);
    csr_cmd = 1'b1; csr_op = op; csr_adr = adr; stall = stl;
    rs1_data = val; csr_uimm = val[4:0];
    @(posedge clk); #1;
    csr_cmd = 1'b0; stall = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; csr_cmd = 1'b0; csr_adr = '0; csr_op = '0; csr_uimm = '0;
    rs1_data = '0; retire = 1'b0; trap_exc = 1'b0; exc_code = '0; exc_tval = '0;
    irq_ack = 1'b0; pc_trap = '0; cmd_mret = 1'b0; ext_irq = 1'b0; tmr_irq = 1'b0;
    sw_irq = 1'b0; lirq = '0;
    repeat (3) cyc();
    chk("rst_irq_req", {31'b0, irq_req}, 32'h0);
    chk("rst_trap_vec", {2'b0, trap_vec}, 32'h0);
    chk("rst_mepc_out", {2'b0, mepc_out}, 32'h0);
    rst_n = 1'b1;
    peek(12'hB00, d, il); chk("rst_mcycle", d, 32'h0);
    peek(12'h300, d, il); chk("rst_mstatus", d, 32'h0);

    // mtvec MODE legalisation
    wr(3'b001, 12'h305, 32'h0000_1001, 1'b0);
    peek(12'h305, d, il); chk("mtvec_vec", d, 32'h0000_1001);
    wr(3'b001, 12'h305, 32'h0000_1003, 1'b0);
    peek(12'h305, d, il); chk("mtvec_mode3", d, 32'h0000_1000);
    wr(3'b001, 12'h305, 32'h0000_1001, 1'b0);

    // mscratch: stall blocks, then RW / RC / RSI
    wr(3'b001, 12'h340, 32'h0000_A5A5, 1'b1);
    peek(12'h340, d, il); chk("stall_blocks_wr", d, 32'h0);
    wr(3'b001, 12'h340, 32'h0000_A5A5, 1'b0);
    peek(12'h340, d, il); chk("mscratch_rw", d, 32'h0000_A5A5);
    wr(3'b011, 12'h340, 32'h0000_00F0, 1'b0);
    peek(12'h340, d, il); chk("mscratch_rc", d, 32'h0000_A505);
    wr(3'b110, 12'h340, 32'h0000_001A, 1'b0);
    peek(12'h340, d, il); chk("mscratch_rsi", d, 32'h0000_A51F);

    // interrupt: sw(3) beats tmr(7), vectored target
    wr(3'b001, 12'h304, 32'h0000_0888, 1'b0);
    wr(3'b001, 12'h300, 32'h0000_0008, 1'b0);
    tmr_irq = 1'b1; sw_irq = 1'b1;
    #1 chk("irq_latency0", {31'b0, irq_req}, 32'h0);
    cyc();
    chk("irq_req_set", {31'b0, irq_req}, 32'h1);
    irq_ack = 1'b1; pc_trap = 30'h40;
    #1 chk("trap_vec_irq3", {2'b0, trap_vec}, 32'h0000_0403);
    cyc(); irq_ack = 1'b0;
    peek(12'h342, d, il); chk("mcause_irq3", d, 32'h8000_0003);
    peek(12'h341, d, il); chk("mepc_irq", d, 32'h0000_0100);
    peek(12'h300, d, il); chk("mstatus_irq", d, 32'h0000_1880);
    chk("mepc_out", {2'b0, mepc_out}, 32'h0000_0040);
    chk("irq_req_masked", {31'b0, irq_req}, 32'h0);

    // exception wins over a simultaneous ack; then mret
    wr(3'b001, 12'h300, 32'h0000_0008, 1'b0);
    trap_exc = 1'b1; exc_code = 4'd2; exc_tval = 32'hDEAD_BEEF; irq_ack = 1'b1; pc_trap = 30'h80;
    #1 chk("trap_vec_exc", {2'b0, trap_vec}, 32'h0000_0400);
    cyc(); trap_exc = 1'b0; irq_ack = 1'b0;
    peek(12'h342, d, il); chk("mcause_exc", d, 32'h0000_0002);
    peek(12'h343, d, il); chk("mtval_exc", d, 32'hDEAD_BEEF);
    peek(12'h300, d, il); chk("mstatus_exc", d, 32'h0000_1880);
    cmd_mret = 1'b1; cyc(); cmd_mret = 1'b0;
    peek(12'h300, d, il); chk("mstatus_mret", d, 32'h0000_1888);
    chk("irq_req_after_mret", {31'b0, irq_req}, 32'h1);
    tmr_irq = 1'b0; sw_irq = 1'b0;
    wr(3'b001, 12'h300, 32'h0, 1'b0);

    // mcycle carry and inhibit
    wr(3'b001, 12'hB80, 32'h0, 1'b0);
    wr(3'b001, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    peek(12'hB00, d, il); chk("mcycle_written", d, 32'hFFFF_FFFF);
    cyc();
    peek(12'hB80, d, il); chk("mcycleh_carry", d, 32'h1);
    peek(12'hB00, d, il); chk("mcycle_wrap", d, 32'h0);
    peek(12'hC80, d, il); chk("cycleh_alias", d, 32'h1);
    wr(3'b001, 12'h320, 32'h1, 1'b0);
    repeat (10) cyc();
    peek(12'hB00, d, il); chk("mcycle_frozen", d, 32'h1);
    peek(12'hB80, d, il); chk("mcycleh_frozen", d, 32'h1);

    // minstret: stalled retire does not count
    retire = 1'b1;
    repeat (3) cyc();
    stall = 1'b1; cyc(); stall = 1'b0; retire = 1'b0;
    peek(12'hB02, d, il); chk("minstret", d, 32'h3);

    // illegal accesses
    csr_cmd = 1'b1; csr_op = 3'b110; csr_adr = 12'hC00; csr_uimm = 5'd0;
    #1 chk("illegal_c00_rs0", {31'b0, illegal_csr}, 32'h1);
    cyc(); csr_cmd = 1'b0;
    peek(12'hB00, d, il); chk("c00_no_change", d, 32'h1);
    csr_cmd = 1'b1; csr_op = 3'b001; csr_adr = 12'hC02; rs1_data = 32'h55;
    #1 chk("illegal_c02_rw", {31'b0, illegal_csr}, 32'h1);
    cyc(); csr_cmd = 1'b0;
    peek(12'hB02, d, il); chk("c02_no_change", d, 32'h3);
    peek(12'h7C0, d, il);
    chk("illegal_7c0", {31'b0, il}, 32'h1);
    chk("rd_7c0", d, 32'h0);
    peek(12'h344, d, il); chk("mip_write_legal", {31'b0, il}, 32'h0);

    // local interrupts: tmr(7) beats lirq[2](18), then 18 alone
    lirq = 4'b0100; tmr_irq = 1'b1;
    wr(3'b001, 12'h304, 32'h0004_0080, 1'b0);
    wr(3'b001, 12'h300, 32'h0000_0008, 1'b0);
    irq_ack = 1'b1;
    #1 chk("trap_vec_irq7", {2'b0, trap_vec}, 32'h0000_0407);
    cyc(); irq_ack = 1'b0;
    peek(12'h342, d, il); chk("mcause_irq7", d, 32'h8000_0007);
    tmr_irq = 1'b0;
    wr(3'b001, 12'h300, 32'h0000_0008, 1'b0);
    irq_ack = 1'b1;
    #1 chk("trap_vec_irq18", {2'b0, trap_vec}, 32'h0000_0412);
    cyc(); irq_ack = 1'b0;
    peek(12'h342, d, il); chk("mcause_irq18", d, 32'h8000_0012);

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    peek(12'h342, d, il); chk("arst_mcause", d, 32'h0);
    peek(12'hB02, d, il); chk("arst_minstret", d, 32'h0);
    chk("arst_trap_vec", {2'b0, trap_vec}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csr_mtrap_unit.md
Name: csr_mtrap_unit

Overview:
- Parametrised machine-mode CSR and trap unit; next generation of the core's CSR block.
- Sits in EX beside the ALU. Executes CSRRW/S/C (register and immediate forms) and holds mstatus/mie/mip/mtvec/mscratch/mepc/mcause/mtval.
- Adds to the previous block: 64-bit cycle/instret counters, mcountinhibit, configurable local interrupts with fixed-priority arbitration, vectored mtvec, mtval, and illegal-CSR detection.
- Fetch/IF takes trap_vec and mepc_out for redirects.

Parameters:
NUM_LIRQ, 4, number of local interrupt lines (0..16), mapped to mip/mie bits 16+i
VECTORED, 1, 1 allows mtvec MODE=1; 0 forces MODE to 0 (WARL)
CNT_W, 64, counter width (32..64); unimplemented upper bits read 0
MISA_VAL, 32'h4000_0100, read-only misa value

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline stall; blocks CSR writes and retire counting
csr_cmd  in  1  CSR instruction valid in EX
csr_adr  in  12  CSR address
csr_op  in  3  funct3: [2] immediate, [1:0] 01 RW / 10 RS / 11 RC
csr_uimm  in  5  zimm
rs1_data  in  32  rs1 operand
csr_rd_data  out  32  old CSR value (combinational)
illegal_csr  out  1  csr_cmd to unimplemented address, or write to read-only (0xC00-0xC82)
retire  in  1  one instruction retired this cycle
trap_exc  in  1  take synchronous exception this cycle
exc_code  in  4  exception cause code
exc_tval  in  32  faulting address or instruction
irq_ack  in  1  pipeline takes the pending interrupt this cycle
pc_trap  in  30  PC[31:2] to save in mepc
cmd_mret  in  1  MRET in EX
ext_irq, tmr_irq, sw_irq  in  1 each  level interrupt inputs
lirq  in  NUM_LIRQ  local level interrupts
irq_req  out  1  enabled interrupt pending
trap_vec  out  30  trap target PC[31:2]
mepc_out  out  30  mepc[31:2]

Behaviour:
- Reset: all CSRs 0; mip 0; irq_req=0; trap_vec=0; mepc_out=0; counters 0.
- Address map:
  - mstatus 300 (MIE[3], MPIE[7], MPP[12:11] only), misa 301, mie 304, mtvec 305, mcountinhibit 320 (bits 0,2), mscratch 340, mepc 341, mcause 342, mtval 343, mip 344 (read-only; writes ignored, not illegal).
  - mcycle/h B00/B80, minstret/h B02/B82.
  - cycle/h C00/C80, instret/h C02/C82: read-only aliases.
- Write data:
  - source = imm ? zero-extended uimm : rs1_data.
  - RW: source. RS: old|source. RC: old&~source.
  - Commits on the clock edge when csr_cmd & ~stall & ~illegal_csr.
  - RS/RC with zero source still counts as a write; a read-only alias is therefore illegal even with a zero source.
- mip: bits 11/7/3/16+i registered from ext/tmr/sw/lirq each cycle, 1-cycle latency.
- Interrupt request:
  - pend = mip & mie; irq_req = mstatus.MIE & |pend (combinational from registers).
  - Priority: 11 > 3 > 7 > 16+0 > 16+1 ... .
- Trap priority per cycle: trap_exc > irq_ack > cmd_mret > CSR write. A CSR write to a field also updated by the winning event is dropped.
- Exception (trap_exc):
  - mcause={0,28'd0,exc_code}; mtval=exc_tval; mepc=pc_trap.
  - MPIE=MIE; MIE=0; MPP=11.
- Interrupt (irq_ack & irq_req):
  - mcause={1,highest-priority code}; mtval=0; mepc and mstatus as for an exception.
  - irq_ack without irq_req is ignored.
- mret: MIE=MPIE; MPIE=1; MPP=11.
- trap_vec (combinational):
  - base = mtvec[31:2].
  - If VECTORED and MODE=1 and the interrupt path is taken: base + selected code, i.e. +4*code bytes.
  - Otherwise base; exceptions always go to base.
- mtvec MODE: write values 2/3 legalise to 0; MODE=1 legalises to 0 when VECTORED=0.
- mepc bits [1:0] read 0.
- Counters:
  - mcycle +1 every cycle unless inhibit[0].
  - minstret +1 when retire & ~stall & ~inhibit[2].
  - Wrap modulo 2^CNT_W.
  - A CSR write to a half replaces that half and suppresses the increment that cycle; the other half is held.
- Reset mid-operation clears everything immediately (asynchronous); no pending-trap memory survives.

Test Plan:
- Reset, then CSRRW mtvec=0x0000_1001 (VECTORED=1) -> read 0x0000_1001; write 0x0000_1003 -> read 0x0000_1000.
- mie=0x0000_0888, MIE=1, tmr_irq and sw_irq both high -> irq_req after 1 cycle. irq_ack with pc_trap=0x40 -> mcause=0x8000_0003, mepc=0x100, MIE=0, MPIE=1, trap_vec=base+3.
- trap_exc (exc_code=2, tval=0xDEAD_BEEF) and irq_ack in the same cycle -> mcause=2, mtval=0xDEAD_BEEF. mret -> MIE restored to 1.
- mcycle=0xFFFF_FFFF, mcycleh=0 -> next cycle mcycleh=1, mcycle=0. Set inhibit[0] -> value frozen across 10 cycles.
- CSRRS to C00 with uimm=0 -> illegal_csr=1 and no state change. Read of 0x7C0 -> illegal_csr=1, csr_rd_data=0.
- NUM_LIRQ=4, lirq[2] high, mie[18]=1, tmr_irq high with mie[7]=1 -> ack selects cause 7. Drop tmr_irq -> next ack gives cause 18.
